// File: rtl/vlog_lex_pkg.sv
// Shared types, ASCII constants and character-class helpers for the Verilog identifier lexer.
package vlog_lex_pkg;

  typedef enum logic [1:0] {
    TokSimple    = 2'd0,
    TokEscExtra  = 2'd1,
    TokEscNeeded = 2'd2,
    TokSystem    = 2'd3
  } tok_kind_e;

  typedef enum logic [3:0] {
    StIdle,
    StSimple,
    StSystem,
    StNumber,
    StEscFirst,
    StEscaped,
    StString,
    StStrBsl,
    StSlash,
    StLineCmt
  } state_e;

  localparam logic [7:0] ChTab    = 8'h09;
  localparam logic [7:0] ChLf     = 8'h0a;
  localparam logic [7:0] ChCr     = 8'h0d;
  localparam logic [7:0] ChSpace  = 8'h20;
  localparam logic [7:0] ChQuote  = 8'h22;
  localparam logic [7:0] ChDollar = 8'h24;
  localparam logic [7:0] ChSlash  = 8'h2f;
  localparam logic [7:0] ChBsl    = 8'h5c;
  localparam logic [7:0] ChUnder  = 8'h5f;

  function automatic logic is_digit(logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_id0(logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5a)) || ((c >= 8'h61) && (c <= 8'h7a)) || (c == ChUnder);
  endfunction

  function automatic logic is_idc(logic [7:0] c);
    return is_id0(c) || is_digit(c) || (c == ChDollar);
  endfunction

  function automatic logic is_ws(logic [7:0] c);
    return (c == ChSpace) || (c == ChTab) || (c == ChCr) || (c == ChLf);
  endfunction

endpackage

// File: rtl/vlog_ident_scanner_if.sv
// Byte-stream input and token-descriptor output of the identifier scanner.
interface vlog_ident_scanner_if #(
  parameter int unsigned OFFS_W = 16,
  parameter int unsigned LEN_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              tok_valid;
  logic              tok_ready;
  logic [OFFS_W-1:0] tok_start;
  logic [LEN_W-1:0]  tok_len;
  logic [1:0]        tok_kind;
  logic              tok_ovf;
  logic              err_unterm;

  modport master (
    output in_valid, in_data, in_last, tok_ready,
    input  in_ready, tok_valid, tok_start, tok_len, tok_kind, tok_ovf, err_unterm
  );

  modport slave (
    input  in_valid, in_data, in_last, tok_ready,
    output in_ready, tok_valid, tok_start, tok_len, tok_kind, tok_ovf, err_unterm
  );
endinterface

// File: rtl/vlog_tok_reg.sv
// Single-entry valid/ready descriptor register; a push may coincide with the drain of the
// previous entry.
module vlog_tok_reg
  import vlog_lex_pkg::*;
#(
  parameter int unsigned OFFS_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              push,
  input  logic [OFFS_W-1:0] push_start,
  input  logic [LEN_W-1:0]  push_len,
  input  tok_kind_e         push_kind,
  input  logic              push_ovf,
  output logic              can_accept,
  output logic              valid,
  input  logic              ready,
  output logic [OFFS_W-1:0] start,
  output logic [LEN_W-1:0]  len,
  output tok_kind_e         kind,
  output logic              ovf
);

  logic              valid_q;
  logic [OFFS_W-1:0] start_q;
  logic [LEN_W-1:0]  len_q;
  tok_kind_e         kind_q;
  logic              ovf_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      valid_q <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      kind_q  <= TokSimple;
      ovf_q   <= 1'b0;
    end else if (push) begin
      valid_q <= 1'b1;
      start_q <= push_start;
      len_q   <= push_len;
      kind_q  <= push_kind;
      ovf_q   <= push_ovf;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign can_accept = !(valid_q && !ready);
  assign valid      = valid_q;
  assign start      = start_q;
  assign len        = len_q;
  assign kind       = kind_q;
  assign ovf        = ovf_q;

endmodule

// File: rtl/vlog_ident_scanner.sv
// Streaming Verilog lexer front-end: finds identifiers in a byte stream, skipping strings and
// line comments, and reports offset, length and escape class for each.
module vlog_ident_scanner
  import vlog_lex_pkg::*;
#(
  parameter int unsigned OFFS_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input logic                 clk,
  input logic                 reset_l,
  vlog_ident_scanner_if.slave bus
);

  localparam logic [LEN_W-1:0] LenMax = '1;

  state_e            state_q, state_d;
  logic [OFFS_W-1:0] offs_q, offs_d;
  logic [OFFS_W-1:0] start_q, start_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              esc_ok_q, esc_ok_d;
  logic              err_q, err_d;
  logic              rdy_en_q;

  logic              accept;
  logic              can_accept;
  logic              idle_proc;
  logic              emit;
  logic [OFFS_W-1:0] emit_start;
  logic [LEN_W-1:0]  emit_len;
  tok_kind_e         emit_kind;
  logic              emit_ovf;
  logic [7:0]        b;
  tok_kind_e         out_kind;

  assign b            = bus.in_data;
  assign bus.in_ready = rdy_en_q && can_accept;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d    = state_q;
    offs_d     = offs_q;
    start_d    = start_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    esc_ok_d   = esc_ok_q;
    err_d      = 1'b0;
    idle_proc  = 1'b0;
    emit       = 1'b0;
    emit_start = start_q;
    emit_len   = len_q;
    emit_kind  = TokSimple;
    emit_ovf   = ovf_q;

    if (accept) begin
      offs_d = bus.in_last ? '0 : offs_q + 1'b1;

      unique case (state_q)
        StIdle: idle_proc = 1'b1;
        StSimple, StSystem: begin
          if (is_idc(b)) begin
            if (len_q == LenMax) ovf_d = 1'b1;
            else                 len_d = len_q + 1'b1;
          end else begin
            emit      = 1'b1;
            emit_kind = (state_q == StSimple) ? TokSimple : TokSystem;
            idle_proc = 1'b1;
          end
        end
        StNumber: if (!is_idc(b)) idle_proc = 1'b1;
        StEscFirst: begin
          if (is_ws(b)) begin
            state_d = StIdle;
          end else begin
            state_d  = StEscaped;
            len_d    = LEN_W'(1);
            esc_ok_d = is_id0(b);
          end
        end
        StEscaped: begin
          if (is_ws(b)) begin
            emit      = 1'b1;
            emit_kind = esc_ok_q ? TokEscExtra : TokEscNeeded;
            state_d   = StIdle;
          end else begin
            esc_ok_d = esc_ok_q && is_idc(b);
            if (len_q == LenMax) ovf_d = 1'b1;
            else                 len_d = len_q + 1'b1;
          end
        end
        StString: begin
          if (b == ChBsl)        state_d = StStrBsl;
          else if (b == ChQuote) state_d = StIdle;
        end
        StStrBsl: state_d = StString;
        StSlash: begin
          if (b == ChSlash) state_d = StLineCmt;
          else              idle_proc = 1'b1;
        end
        StLineCmt: if (b == ChLf) state_d = StIdle;
        default: idle_proc = 1'b1;
      endcase

      // A terminating byte is re-examined as if the lexer were idle.
      if (idle_proc) begin
        state_d = StIdle;
        if (is_id0(b) || (b == ChDollar)) begin
          state_d = (b == ChDollar) ? StSystem : StSimple;
          start_d = offs_q;
          len_d   = LEN_W'(1);
          ovf_d   = 1'b0;
        end else if (is_digit(b)) begin
          state_d = StNumber;
        end else if (b == ChBsl) begin
          state_d = StEscFirst;
          start_d = offs_q;
          len_d   = '0;
          ovf_d   = 1'b0;
        end else if (b == ChQuote) begin
          state_d = StString;
        end else if (b == ChSlash) begin
          state_d = StSlash;
        end
      end

      // A terminator never opens a new token, so this cannot double-emit.
      if (bus.in_last) begin
        if (state_d inside {StSimple, StSystem, StEscaped}) begin
          emit       = 1'b1;
          emit_start = start_d;
          emit_len   = len_d;
          emit_ovf   = ovf_d;
          unique case (state_d)
            StSimple: emit_kind = TokSimple;
            StSystem: emit_kind = TokSystem;
            default:  emit_kind = esc_ok_d ? TokEscExtra : TokEscNeeded;
          endcase
        end
        err_d   = state_d inside {StString, StStrBsl};
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= StIdle;
      offs_q   <= '0;
      start_q  <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      esc_ok_q <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      offs_q   <= offs_d;
      start_q  <= start_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      esc_ok_q <= esc_ok_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  vlog_tok_reg #(
    .OFFS_W (OFFS_W),
    .LEN_W  (LEN_W)
  ) u_tok_reg (
    .clk        (clk),
    .reset_l    (reset_l),
    .push       (emit),
    .push_start (emit_start),
    .push_len   (emit_len),
    .push_kind  (emit_kind),
    .push_ovf   (emit_ovf),
    .can_accept (can_accept),
    .valid      (bus.tok_valid),
    .ready      (bus.tok_ready),
    .start      (bus.tok_start),
    .len        (bus.tok_len),
    .kind       (out_kind),
    .ovf        (bus.tok_ovf)
  );

  assign bus.tok_kind   = out_kind;
  assign bus.err_unterm = err_q;

endmodule

// File: tb/tb_vlog_ident_scanner.sv
// Directed bench for vlog_ident_scanner: short source snippets with hand-derived token lists.
module tb_vlog_ident_scanner;

  typedef struct packed {
    logic [15:0] start;
    logic [7:0]  len;
    logic [1:0]  kind;
    logic        ovf;
  } tok_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   err_cnt = 0;
  tok_t tok_q[$];
  tok_t tok4_q[$];

  always #5 clk = ~clk;

  vlog_ident_scanner_if #(.OFFS_W(16), .LEN_W(8)) bus ();
  vlog_ident_scanner_if #(.OFFS_W(16), .LEN_W(4)) bus4 ();

  vlog_ident_scanner #(.OFFS_W(16), .LEN_W(8)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  vlog_ident_scanner #(.OFFS_W(16), .LEN_W(4)) dut4 (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus4)
  );

  function automatic tok_t mk(int s, int l, int k, int o);
    tok_t t;
    t.start = 16'(s);
    t.len   = 8'(l);
    t.kind  = 2'(k);
    t.ovf   = 1'(o);
    return t;
  endfunction

  // Inputs change #1 after posedge, so the negedge sees the handshake of the coming edge.
  always @(negedge clk) begin
    if (bus.tok_valid && bus.tok_ready)
      tok_q.push_back(mk(int'(bus.tok_start), int'(bus.tok_len), int'(bus.tok_kind),
                         int'(bus.tok_ovf)));
    if (bus4.tok_valid && bus4.tok_ready)
      tok4_q.push_back(mk(int'(bus4.tok_start), int'(bus4.tok_len), int'(bus4.tok_kind),
                          int'(bus4.tok_ovf)));
    if (bus.err_unterm) err_cnt++;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic last);
    int   n = 0;
    logic rdy;
    if (sel == 0) begin
      bus.in_valid = 1'b1; bus.in_data = b; bus.in_last = last;
    end else begin
      bus4.in_valid = 1'b1; bus4.in_data = b; bus4.in_last = last;
    end
    while (1) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus.in_ready : bus4.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        compared++;
        mismatched++;
        $display("FAIL handshake_timeout: in_ready got 0 for %0d cycles want 1", n);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus4.in_last = 1'b0;
  endtask

  task automatic send_str(input int sel, input string s, input logic last_at_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(sel, s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    @(negedge clk);
    compared++; if (bus.tok_valid !== 1'b0) begin mismatched++;
      $display("FAIL reset_tok_valid: got %0d want 0", bus.tok_valid); end
    compared++; if (bus.tok_start !== 16'd0) begin mismatched++;
      $display("FAIL reset_tok_start: got %0d want 0", bus.tok_start); end
    compared++; if (bus.tok_len !== 8'd0) begin mismatched++;
      $display("FAIL reset_tok_len: got %0d want 0", bus.tok_len); end
    compared++; if (bus.tok_kind !== 2'd0 || bus.tok_ovf !== 1'b0) begin mismatched++;
      $display("FAIL reset_kind_ovf: got %0d/%0d want 0/0", bus.tok_kind, bus.tok_ovf); end
    compared++; if (bus.err_unterm !== 1'b0) begin mismatched++;
      $display("FAIL reset_err_unterm: got %0d want 0", bus.err_unterm); end
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++;
      $display("FAIL reset_in_ready: got %0d want 0", bus.in_ready); end
    @(posedge clk);
    #1 reset_l = 1'b1;
    #1;
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++;
      $display("FAIL release_in_ready_early: got %0d want 0", bus.in_ready); end
    @(posedge clk);
    #1;
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++;
      $display("FAIL release_in_ready: got %0d want 1", bus.in_ready); end
  endtask

  task automatic test_simple();
    int   base = tok_q.size();
    tok_t exp[2];
    tok_t got;
    exp[0] = mk(0, 4, 0, 0);
    exp[1] = mk(5, 2, 0, 0);
    send_str(0, "wire do;", 1'b1);
    idle_cycles(4);
    compared++; if (tok_q.size() - base !== 2) begin mismatched++;
      $display("FAIL simple_count: got %0d want 2", tok_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (base + i < tok_q.size()) begin
        got = tok_q[base + i];
        compared++; if (got !== exp[i]) begin mismatched++;
          $display("FAIL simple_tok%0d: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i,
                   got.start, got.len, got.kind, got.ovf,
                   exp[i].start, exp[i].len, exp[i].kind, exp[i].ovf); end
      end
    end
  endtask

  task automatic test_escaped();
    int   base = tok_q.size();
    tok_t exp[2];
    tok_t got;
    exp[0] = mk(0, 8, 1, 0);
    exp[1] = mk(0, 13, 2, 0);
    send_str(0, "\\ext_2non ;", 1'b1);
    send_str(0, "\\esc[ape]_2non ;", 1'b1);
    send_str(0, "\\ ;", 1'b1);
    idle_cycles(4);
    compared++; if (tok_q.size() - base !== 2) begin mismatched++;
      $display("FAIL escaped_count: got %0d want 2", tok_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (base + i < tok_q.size()) begin
        got = tok_q[base + i];
        compared++; if (got !== exp[i]) begin mismatched++;
          $display("FAIL escaped_tok%0d: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i,
                   got.start, got.len, got.kind, got.ovf,
                   exp[i].start, exp[i].len, exp[i].kind, exp[i].ovf); end
      end
    end
  endtask

  task automatic test_system();
    int   base = tok_q.size();
    int   err0 = err_cnt;
    tok_t exp = mk(0, 8, 3, 0);
    tok_t got;
    send_str(0, "$display(\"foo.foo\");", 1'b1);
    idle_cycles(4);
    compared++; if (tok_q.size() - base !== 1) begin mismatched++;
      $display("FAIL system_count: got %0d want 1", tok_q.size() - base); end
    if (base < tok_q.size()) begin
      got = tok_q[base];
      compared++; if (got !== exp) begin mismatched++;
        $display("FAIL system_tok: got (%0d,%0d,%0d,%0d) want (0,8,3,0)",
                 got.start, got.len, got.kind, got.ovf); end
    end
    compared++; if (err_cnt - err0 !== 0) begin mismatched++;
      $display("FAIL system_err_unterm: got %0d pulses want 0", err_cnt - err0); end
  endtask

  task automatic test_comment();
    int   base = tok_q.size();
    tok_t exp = mk(10, 1, 0, 0);
    tok_t got;
    send_str(0, "// wire x\nq ", 1'b1);
    idle_cycles(4);
    compared++; if (tok_q.size() - base !== 1) begin mismatched++;
      $display("FAIL comment_count: got %0d want 1", tok_q.size() - base); end
    if (base < tok_q.size()) begin
      got = tok_q[base];
      compared++; if (got !== exp) begin mismatched++;
        $display("FAIL comment_tok: got (%0d,%0d,%0d,%0d) want (10,1,0,0)",
                 got.start, got.len, got.kind, got.ovf); end
    end
  endtask

  task automatic test_back_to_back();
    int   base = tok_q.size();
    tok_t exp[3];
    tok_t got;
    exp[0] = mk(0, 1, 0, 0);
    exp[1] = mk(2, 1, 0, 0);
    exp[2] = mk(4, 1, 0, 0);
    bus.tok_ready = 1'b0;
    send_byte(0, "a", 1'b0);
    send_byte(0, " ", 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = "b";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++; if (bus.tok_valid !== 1'b1) begin mismatched++;
        $display("FAIL stall_tok_valid c%0d: got %0d want 1", i, bus.tok_valid); end
      compared++; if (bus.tok_start !== 16'd0 || bus.tok_len !== 8'd1) begin mismatched++;
        $display("FAIL stall_hold c%0d: got (%0d,%0d) want (0,1)", i, bus.tok_start,
                 bus.tok_len); end
      compared++; if (bus.in_ready !== 1'b0) begin mismatched++;
        $display("FAIL stall_in_ready c%0d: got %0d want 0", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    bus.tok_ready = 1'b1;
    send_str(0, "b c ", 1'b1);
    idle_cycles(4);
    compared++; if (tok_q.size() - base !== 3) begin mismatched++;
      $display("FAIL b2b_count: got %0d want 3", tok_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < tok_q.size()) begin
        got = tok_q[base + i];
        compared++; if (got !== exp[i]) begin mismatched++;
          $display("FAIL b2b_tok%0d: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i,
                   got.start, got.len, got.kind, got.ovf,
                   exp[i].start, exp[i].len, exp[i].kind, exp[i].ovf); end
      end
    end
  endtask

  task automatic test_overflow();
    int   base = tok4_q.size();
    tok_t exp = mk(0, 15, 0, 1);
    tok_t got;
    send_str(1, "abcdefghijklmnopqrst", 1'b1);
    idle_cycles(4);
    compared++; if (tok4_q.size() - base !== 1) begin mismatched++;
      $display("FAIL ovf_count: got %0d want 1", tok4_q.size() - base); end
    if (base < tok4_q.size()) begin
      got = tok4_q[base];
      compared++; if (got !== exp) begin mismatched++;
        $display("FAIL ovf_tok: got (%0d,%0d,%0d,%0d) want (0,15,0,1)",
                 got.start, got.len, got.kind, got.ovf); end
    end
  endtask

  task automatic test_unterm();
    int base = tok_q.size();
    int err0 = err_cnt;
    send_str(0, "\"abc", 1'b1);
    idle_cycles(4);
    compared++; if (err_cnt - err0 !== 1) begin mismatched++;
      $display("FAIL unterm_err: got %0d pulses want 1", err_cnt - err0); end
    compared++; if (tok_q.size() - base !== 0) begin mismatched++;
      $display("FAIL unterm_count: got %0d want 0", tok_q.size() - base); end
  endtask

  task automatic test_reset_mid();
    int   base;
    tok_t exp = mk(0, 2, 0, 0);
    tok_t got;
    send_str(0, "abc", 1'b0);
    reset_l = 1'b0;
    @(posedge clk);
    #1 reset_l = 1'b1;
    @(posedge clk);
    #1;
    base = tok_q.size();
    send_str(0, "xy ", 1'b1);
    idle_cycles(4);
    compared++; if (tok_q.size() - base !== 1) begin mismatched++;
      $display("FAIL rstmid_count: got %0d want 1", tok_q.size() - base); end
    if (base < tok_q.size()) begin
      got = tok_q[base];
      compared++; if (got !== exp) begin mismatched++;
        $display("FAIL rstmid_tok: got (%0d,%0d,%0d,%0d) want (0,2,0,0)",
                 got.start, got.len, got.kind, got.ovf); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.tok_ready = 1'b1;
    bus4.in_valid = 1'b0;
    bus4.in_data = 8'h00;
    bus4.in_last = 1'b0;
    bus4.tok_ready = 1'b1;
    test_reset();
    test_simple();
    test_escaped();
    test_system();
    test_comment();
    test_back_to_back();
    test_overflow();
    test_unterm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vlog_ident_scanner.md
Name: vlog_ident_scanner

Overview:
- Streaming lexer front-end, one byte per cycle of Verilog source text.
- Locates every identifier and reports start offset, length and escape class. Escape classes: simple, escaped but unnecessary, escaped and necessary, system task.
- Sits directly upstream of the rename/substitution stage. That stage consumes the token descriptors and rewrites the names.
- Skips string literals and `//` line comments, so no tokens are produced from them.

Parameters:
- OFFS_W, 16: width of byte-offset counter; wraps modulo 2^OFFS_W.
- LEN_W, 8: width of token length; saturates at 2^LEN_W-1.

Ports:
- clk  in  1  clock
- reset_l  in  1  asynchronous active-low reset
- in_valid  in  1  source byte valid
- in_ready  out  1  source byte accepted when in_valid&&in_ready
- in_data  in  8  source byte (ASCII)
- in_last  in  1  final byte of the stream
- tok_valid  out  1  token descriptor valid
- tok_ready  in  1  downstream accepts descriptor
- tok_start  out  OFFS_W  offset of first token byte (the backslash for escaped names)
- tok_len  out  LEN_W  name bytes, excluding backslash and terminating whitespace
- tok_kind  out  2  0 SIMPLE, 1 ESC_EXTRA, 2 ESC_NEEDED, 3 SYSTEM
- tok_ovf  out  1  length saturated
- err_unterm  out  1  one-cycle pulse: stream ended inside a string

Behaviour:
- Clock and reset: one clock, clk. reset_l is asynchronous, active-low. While reset is asserted:
  - tok_valid=0, tok_start=0, tok_len=0, tok_kind=0, tok_ovf=0, err_unterm=0, in_ready=0.
  - State=IDLE, offset=0.
  - in_ready rises on the first clk after reset deasserts.
  - A reset mid-token or mid-stream discards all partial state.
- Output handshake:
  - The output is a single-entry register. in_ready = !(tok_valid && !tok_ready).
  - The descriptor holds stable while tok_valid && !tok_ready.
  - Latency: tok_valid rises the cycle after the terminating byte (or the in_last byte) is accepted.
- Offset counter: increments per accepted byte, wraps, and returns to 0 after an in_last byte.
- Character classes: ID0 = [A-Za-z_]; IDC = [A-Za-z0-9_$]; WS = space, tab, CR, LF.
- States:
  - IDLE:
    - ID0 -> SIMPLE.
    - '$' -> SYSTEM; '$' is counted in the length.
    - digit -> NUMBER.
    - '\' -> ESC_FIRST.
    - '"' -> STRING.
    - '/' -> SLASH.
    - Any other byte stays in IDLE.
  - SIMPLE / SYSTEM: IDC extends the token. Any other byte emits the token, then that byte is processed as in IDLE in the same cycle.
  - NUMBER: IDC stays in NUMBER. Any other byte is processed as in IDLE. No token is emitted.
  - ESC_FIRST: WS returns to IDLE with no token (empty escape). Any other byte -> ESCAPED.
  - ESCAPED: WS emits the token and consumes the WS byte. Any other byte extends the token.
  - Escaped kind: ESC_EXTRA if the first name byte is in ID0 and all name bytes are in IDC. Otherwise ESC_NEEDED.
  - STRING: '\' -> STR_BSL, which consumes the next byte and returns to STRING. '"' -> IDLE.
  - SLASH: '/' -> LINE_CMT. Any other byte is processed as in IDLE.
  - LINE_CMT: LF -> IDLE.
- in_last:
  - The last byte is processed normally; then any open SIMPLE, SYSTEM or ESCAPED token is emitted, ending at that byte.
  - If the last byte is a terminator, exactly one token is emitted, never two.
  - Ending in STRING or STR_BSL pulses err_unterm.
  - State returns to IDLE.
- Length: counts up to 2^LEN_W-1. Further bytes still extend the token, and tok_ovf=1 for that token.

Decomposition:
- Package vlog_lex_pkg holds:
  - tok_kind_e (SIMPLE, ESC_EXTRA, ESC_NEEDED, SYSTEM);
  - state enum;
  - ASCII constants;
  - pure functions is_id0, is_idc, is_ws.
- Sub-module vlog_tok_reg: the single-entry valid/ready output register with its stall logic.

Test Plan:
- "wire do;" with in_last on ';' -> (start 0, len 4, SIMPLE), then (5, 2, SIMPLE); nothing else.
- "\ext_2non ;" -> (0, 8, ESC_EXTRA). "\esc[ape]_2non ;" -> (0, 13, ESC_NEEDED). "\ ;" -> no token.
- `$display("foo.foo");` -> only (0, 8, SYSTEM). No tokens from the string contents; err_unterm stays 0.
- "// wire x\nq " -> only (10, 1, SIMPLE).
- "a b c " with tok_ready held 0 for 5 cycles:
  - tok_valid=1 with (0,1) held stable;
  - in_ready=0 during the stall;
  - after release, tokens arrive in order (0,1), (2,1), (4,1).
- Cases with in_last on the final byte:
  - LEN_W=4 with a 20-char simple identifier -> len 15, tok_ovf=1.
  - `"abc` -> err_unterm pulse, no token.
  - Reset asserted mid-identifier -> no token; offset restarts at 0.
